// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache back-end memory arbiter.
// Holds the FSM encoding and the round-robin step helper.
package cache_mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_MASTERS = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_BURST_W = 3;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side native bus bundle for the arbiter.
// slave is the arbiter view, master is the caches-plus-memory view.
interface cache_mem_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int NBYTES = DATA_W / 8;

  logic [N_MASTERS-1:0]        m_valid;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS*NBYTES-1:0] m_wstrb;
  logic [DATA_W-1:0]           m_rdata;
  logic [N_MASTERS-1:0]        m_ready;

  logic                        mem_valid;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [NBYTES-1:0]           mem_wstrb;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        mem_ready;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    input  mem_rdata, mem_ready,
    output m_rdata, m_ready,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    output mem_rdata, mem_ready,
    input  m_rdata, m_ready,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/cache_mem_arbiter_rr_prio_enc.sv
// Round-robin priority encoder: first set req bit at or after ptr.
// Pure combinational, scans ptr, ptr+1, ... wrapping modulo N_MASTERS.
module rr_prio_enc #(
  parameter int N_MASTERS = 2,
  parameter int MASTER_W  = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [MASTER_W-1:0]  ptr,
  output logic [MASTER_W-1:0]  gnt_idx,
  output logic                 gnt_vld
);

  int sum;
  logic [MASTER_W-1:0] idx;

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= N_MASTERS) sum = sum - N_MASTERS;
      idx = MASTER_W'(sum);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one native memory port between cache back-ends.
// Consecutive read beats keep the grant so a line refill is never interleaved.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int N_MASTERS = DEF_MASTERS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NBYTES    = DATA_W / 8,
  parameter int MASTER_W  = $clog2(N_MASTERS),
  parameter int BURST_W   = DEF_BURST_W
) (
  input  logic                clk,
  input  logic                reset,
  cache_mem_arbiter_if.slave  bus,
  output logic                busy,
  output logic [MASTER_W-1:0] grant
);

  localparam logic [BURST_W:0] LAST_BEAT =
    (BURST_W + 1)'((1 << BURST_W) - 1);

  arb_state_e          state;
  logic [MASTER_W-1:0] grant_r;
  logic [MASTER_W-1:0] rr_ptr;
  logic [MASTER_W-1:0] win_idx;
  logic                win_vld;
  logic [BURST_W:0]    beat_cnt;

  logic                is_busy;
  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NBYTES-1:0]   sel_wstrb;
  logic                out_valid;
  logic                beat_done;
  logic                is_write;
  logic                last_beat;
  logic                release_now;
  logic [N_MASTERS-1:0] ready;

  rr_prio_enc #(
    .N_MASTERS (N_MASTERS),
    .MASTER_W  (MASTER_W)
  ) u_enc (
    .req     (bus.m_valid),
    .ptr     (rr_ptr),
    .gnt_idx (win_idx),
    .gnt_vld (win_vld)
  );

  always_comb begin
    is_busy     = (state == ARB_BUSY);
    sel_valid   = bus.m_valid[grant_r];
    sel_addr    = bus.m_addr[int'(grant_r)*ADDR_W +: ADDR_W];
    sel_wdata   = bus.m_wdata[int'(grant_r)*DATA_W +: DATA_W];
    sel_wstrb   = bus.m_wstrb[int'(grant_r)*NBYTES +: NBYTES];
    out_valid   = is_busy & sel_valid;
    beat_done   = out_valid & bus.mem_ready;
    is_write    = |sel_wstrb;
    last_beat   = (BURST_W == 0) || (beat_cnt == LAST_BEAT);
    // A dropped valid ends the lock: nothing is outstanding on a native port.
    release_now = !sel_valid || (beat_done && (is_write || last_beat));
    ready          = '0;
    ready[grant_r] = beat_done;
  end

  assign bus.mem_valid = out_valid;
  assign bus.mem_addr  = is_busy ? sel_addr  : '0;
  assign bus.mem_wdata = is_busy ? sel_wdata : '0;
  assign bus.mem_wstrb = is_busy ? sel_wstrb : '0;
  assign bus.m_ready   = ready;
  assign bus.m_rdata   = bus.mem_rdata;
  assign busy          = is_busy;
  assign grant         = grant_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      grant_r  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (win_vld) begin
            grant_r  <= win_idx;
            beat_cnt <= '0;
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (release_now) begin
            state  <= ARB_IDLE;
            rr_ptr <= MASTER_W'(rr_next(int'(grant_r), N_MASTERS));
          end else if (beat_done) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scoreboard bench for cache_mem_arbiter.
// Masters replay request queues; memory answers one cycle after each valid.
module tb_cache_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int MW = 1;
  localparam int BW = 3;
  localparam logic [DW-1:0] KEY = 32'hA5A5_5A5A;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
    int            gap;
  } req_t;

  typedef struct {
    int            m;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NB-1:0] wstrb;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          busy;
  logic [MW-1:0] grant;
  logic          rdy_q = 1'b0;
  logic          stray = 1'b0;
  logic [N-1:0]  fired = '0;

  int   total = 0;
  int   bad   = 0;
  int   nfire = 0;
  int   rcnt[N] = '{default: 0};
  req_t rq[N][$];
  exp_t sb[$];
  exp_t mon_e;
  req_t drv_t;

  cache_mem_arbiter_if #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) bus ();

  cache_mem_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .NBYTES    (NB),
    .MASTER_W  (MW),
    .BURST_W   (BW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .grant (grant)
  );

  always #5 clk = ~clk;

  assign bus.mem_ready = rdy_q | stray;
  assign bus.mem_rdata = bus.mem_addr ^ KEY;

  always @(posedge clk) rdy_q <= !reset && bus.mem_valid && !rdy_q;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input int m, input logic [AW-1:0] a, input int gap);
    req_t r;
    r.addr = a; r.wdata = '0; r.wstrb = '0; r.gap = gap;
    rq[m].push_back(r);
  endtask

  task automatic wr(input int m, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [NB-1:0] s);
    req_t r;
    r.addr = a; r.wdata = d; r.wstrb = s; r.gap = 0;
    rq[m].push_back(r);
  endtask

  task automatic ex_rd(input int m, input logic [AW-1:0] a);
    exp_t e;
    e.m = m; e.addr = a; e.data = a ^ KEY; e.wstrb = '0;
    sb.push_back(e);
  endtask

  task automatic ex_wr(input int m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [NB-1:0] s);
    exp_t e;
    e.m = m; e.addr = a; e.data = d; e.wstrb = s;
    sb.push_back(e);
  endtask

  task automatic wait_fire(input int n, input int budget);
    int c = 0;
    while (nfire < n && c < budget) begin
      tick();
      c++;
    end
    chk("fire_timeout", 64'(nfire >= n), 1);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((sb.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0 || busy)
           && c < budget) begin
      tick();
      c++;
    end
    chk("drain_timeout", 64'(c < budget), 1);
  endtask

  // Handshake monitor: every m_ready pulse pops one scoreboard entry.
  always @(negedge clk) begin
    fired = '0;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (bus.m_ready[i]) begin
          fired[i] = 1'b1;
          nfire++;
          rcnt[i]++;
          chk("sb_nonempty", 64'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("beat_master", i, mon_e.m);
            chk("beat_addr", bus.mem_addr, mon_e.addr);
            chk("beat_wstrb", bus.mem_wstrb, mon_e.wstrb);
            if (mon_e.wstrb != 0) chk("beat_wdata", bus.mem_wdata, mon_e.data);
            else chk("beat_rdata", bus.m_rdata, mon_e.data);
          end
        end
      end
    end
  end

  // Master driver: retire completed beats just after the edge, then present
  // the next queued request (held low while its gap counts down).
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (fired[i] && rq[i].size() > 0) begin
        drv_t = rq[i].pop_front();
      end else if (rq[i].size() > 0 && rq[i][0].gap > 0) begin
        drv_t = rq[i].pop_front();
        drv_t.gap = drv_t.gap - 1;
        rq[i].push_front(drv_t);
      end
      if (rq[i].size() > 0 && rq[i][0].gap == 0) begin
        bus.m_valid[i]           = 1'b1;
        bus.m_addr[i*AW +: AW]   = rq[i][0].addr;
        bus.m_wdata[i*DW +: DW]  = rq[i][0].wdata;
        bus.m_wstrb[i*NB +: NB]  = rq[i][0].wstrb;
      end else begin
        bus.m_valid[i]           = 1'b0;
        bus.m_addr[i*AW +: AW]   = '0;
        bus.m_wdata[i*DW +: DW]  = '0;
        bus.m_wstrb[i*NB +: NB]  = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    int base;
    int r0;
    int r1;
    int c;
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_m_ready", bus.m_ready, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);

    // single-master refill with M1 arriving mid-lock
    reset = 1'b0;
    tick();
    base = nfire; r0 = rcnt[0]; r1 = rcnt[1];
    for (int k = 0; k < 8; k++) begin
      rd(0, 32'h1000 + 32'(4 * k), 0);
      ex_rd(0, 32'h1000 + 32'(4 * k));
    end
    ex_rd(1, 32'h2000);
    tick();
    chk("lat_m_valid", bus.m_valid[0], 1);
    chk("lat_still_idle", bus.mem_valid, 0);
    tick();
    chk("lat_mem_valid", bus.mem_valid, 1);
    chk("lat_grant", grant, 0);
    rd(1, 32'h2000, 0);
    wait_fire(base + 8, 60);
    chk("lock_m0_beats", rcnt[0] - r0, 8);
    chk("lock_no_m1", rcnt[1] - r1, 0);
    tick();
    chk("refill_release", busy, 0);
    drain(40);

    // contention from reset release, single-beat reads
    reset = 1'b1;
    rd(0, 32'h3000, 0); rd(0, 32'h3004, 1);
    rd(1, 32'h4000, 0); rd(1, 32'h4004, 1);
    ex_rd(0, 32'h3000); ex_rd(1, 32'h4000);
    ex_rd(0, 32'h3004); ex_rd(1, 32'h4004);
    tick(); tick();
    reset = 1'b0;
    base = nfire;
    for (int k = 0; k < 4; k++) begin
      wait_fire(base + k + 1, 20);
      chk("rr_grant", grant, exp_g[k]);
      if (k < 3) begin
        c = 0;
        while (busy && c < 6) begin
          tick();
          c++;
        end
        chk("rr_idle", busy, 0);
        chk("rr_ptr", dut.rr_ptr, exp_g[k] ^ 1);
        tick();
        chk("rr_one_idle", busy, 1);
      end
    end
    drain(20);

    // write release: M1 writes while M0 waits
    rd(0, 32'h5000, 0); ex_rd(0, 32'h5000);
    drain(20);
    base = nfire;
    wr(1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    rd(0, 32'h5004, 0);
    ex_wr(1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    ex_rd(0, 32'h5004);
    wait_fire(base + 1, 20);
    tick();
    chk("wr_release", busy, 0);
    drain(30);

    // write arriving mid-lock ends the lock
    rd(0, 32'h6000, 0);
    wr(0, 32'h6004, 32'h1234_5678, 4'h3);
    rd(0, 32'h6008, 0);
    ex_rd(0, 32'h6000);
    ex_wr(0, 32'h6004, 32'h1234_5678, 4'h3);
    ex_rd(1, 32'h7000);
    ex_rd(0, 32'h6008);
    tick(); tick();
    rd(1, 32'h7000, 0);
    drain(40);

    // lock cap: 10 back-to-back reads, M1 gets in after 8
    for (int k = 0; k < 10; k++) rd(0, 32'h8000 + 32'(4 * k), 0);
    for (int k = 0; k < 8; k++) ex_rd(0, 32'h8000 + 32'(4 * k));
    ex_rd(1, 32'h9000);
    ex_rd(0, 32'h8020); ex_rd(0, 32'h8024);
    tick(); tick();
    rd(1, 32'h9000, 0);
    drain(80);

    // valid gap at beat 3 drops the lock
    for (int k = 0; k < 6; k++) rd(0, 32'hA000 + 32'(4 * k), (k == 3) ? 1 : 0);
    for (int k = 0; k < 3; k++) ex_rd(0, 32'hA000 + 32'(4 * k));
    ex_rd(1, 32'hB000);
    for (int k = 3; k < 6; k++) ex_rd(0, 32'hA000 + 32'(4 * k));
    tick(); tick();
    rd(1, 32'hB000, 0);
    drain(60);

    // stray mem_ready in IDLE
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stray_m_ready", bus.m_ready, 0);
      chk("stray_busy", busy, 0);
    end
    stray = 1'b0;
    tick();

    // reset in the middle of an M1 refill
    for (int k = 0; k < 8; k++) begin
      rd(1, 32'hC000 + 32'(4 * k), 0);
      ex_rd(1, 32'hC000 + 32'(4 * k));
    end
    base = nfire;
    wait_fire(base + 4, 40);
    tick();
    chk("pre_rst_grant", grant, 1);
    reset = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_valid", bus.mem_valid, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_rr_ptr", dut.rr_ptr, 0);
    chk("midrst_m_ready", bus.m_ready, 0);
    rq[0].delete();
    rq[1].delete();
    sb.delete();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd(1, 32'hE000 + 32'(4 * k), 0);
      ex_rd(1, 32'hE000 + 32'(4 * k));
    end
    ex_rd(0, 32'hF000);
    tick(); tick();
    chk("restart_grant", grant, 1);
    chk("restart_beat_cnt", dut.beat_cnt, 0);
    rd(0, 32'hF000, 0);
    drain(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
